muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1: clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: asynchronous active-high reset.
REQ-004 Port start, input, 1: request a new operation; sampled only in IDLE.
REQ-005 Port op, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 Port A, input, 32: multiplicand or dividend; sampled with start.
REQ-007 Port B, input, 32: multiplier or divisor; sampled with start.
REQ-008 Port hi_we, input, 1: MTHI write strobe.
REQ-009 Port lo_we, input, 1: MTLO write strobe.
REQ-010 Port wdata, input, 32: MTHI/MTLO data.
REQ-011 Port HI, output, 32: high product word or remainder.
REQ-012 Port LO, output, 32: low product word or quotient.
REQ-013 Port busy, output, 1: operation in progress.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port div_zero, output, 1: last DIV/DIVU had B == 0; held until the next accepted start.

Function
REQ-016 The FSM SHALL have exactly five states, traversed IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
REQ-017 IDLE with start=1 SHALL latch op/A/B and enter PREP; busy SHALL be 1 from the next cycle until DONE exits.
REQ-018 PREP (1 cycle): signed ops SHALL take the operand magnitudes and record the result sign and remainder sign; unsigned ops SHALL pass operands through.
REQ-019 ITER SHALL last exactly 32 cycles, driven by a 5-bit counter, with one shift-add (MULT) or restoring shift-subtract (DIV) step per cycle on the shared adder.
REQ-020 FIX (1 cycle) SHALL apply sign correction: product negated if the signs differ; quotient negated if the signs differ; remainder takes the sign of the dividend.
REQ-021 DONE (1 cycle) SHALL assert done=1 and write HI/LO; the FSM SHALL then return to IDLE.
REQ-022 Latency: done SHALL be high in the cycle following the 35th rising edge after the edge that accepted start.
REQ-023 A start while busy=1 SHALL be ignored, with no queuing.
REQ-024 hi_we/lo_we SHALL write HI/LO only while busy=0; while busy=1 they SHALL be ignored.
REQ-025 If hi_we/lo_we coincide with an accepted start, the write SHALL take effect and the operation SHALL still start.
REQ-026 Divide by zero: HI=A and LO=32'hFFFFFFFF, with div_zero=1 and normal latency.
REQ-027 DIV 0x80000000 / -1 SHALL give LO=0x80000000 and HI=0 with no flag.
REQ-028 HI/LO SHALL hold their previous values during busy and change only in DONE or on a write.

Reset
REQ-029 rst SHALL immediately force state IDLE, HI=0, LO=0, busy=0, done=0, div_zero=0, and counter=0, aborting any operation in progress.
REQ-030 After rst deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-031 Op encodings, FSM state encodings and the ITER count (32) SHALL live in the shared package muldiv_pkg.
REQ-032 The per-step add/subtract SHALL be performed by one instance of the team's ALU (ALUCntl 0010 add, 0110 subtract, CarryIn=0), with CarryOut used as the restoring-divide borrow.
REQ-033 All remaining logic (FSM, counter, shift registers, sign fix) SHALL be local to muldiv_ctrl.

Verification
REQ-034 MULT A=7, B=-3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; done exactly at edge 35.
REQ-035 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=100, B=0 -> HI=100, LO=0xFFFFFFFF, div_zero=1.
REQ-037 DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0, div_zero=0.
REQ-038 Second start at ITER cycle 5 plus hi_we at cycle 6 -> both ignored; first result correct, no second done.
REQ-039 rst asserted at ITER cycle 10 -> same cycle: busy=0, HI=LO=0, done never pulses; a new start after release completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared constants for the iterative multiply/divide unit: operation
// encodings, FSM state encodings, the iteration count and the ALU control
// codes, plus small helpers used when preparing operands.
// No ports (package).
package muldiv_pkg;

    // Operation encodings as presented on the op input.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // One shift-add or shift-subtract step per operand bit.
    localparam int unsigned ITER_COUNT = 32;
    localparam logic [4:0]  ITER_LAST  = 5'(ITER_COUNT - 1);

    // ALU control codes understood by the shared ALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Bit 1 of the op code selects divide, bit 0 selects unsigned.
    function automatic logic isDivOp(input logic [1:0] opCode);
        return opCode[1];
    endfunction

    function automatic logic isSignedOp(input logic [1:0] opCode);
        return ~opCode[0];
    endfunction

    // Absolute value when the operation is signed; 0x80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        takeAbs);
        return (takeAbs && value[31]) ? -value : value;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_alu.sv
// muldiv_ctrl_alu
// The team's 32-bit ALU, used here as the single shared adder of the
// multiply/divide datapath.
// Ports:
//   ALUCntl_i  [3:0]  operation select (0000 AND, 0001 OR, 0010 add, 0110 sub)
//   A_i, B_i   [31:0] operands
//   CarryIn_i         carry into the add
//   ALUOut_o   [31:0] result
//   CarryOut_o        carry out; for subtract it is 1 when A_i >= B_i (no borrow)
module muldiv_ctrl_alu (
    input  logic [3:0]  ALUCntl_i,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    input  logic        CarryIn_i,
    output logic [31:0] ALUOut_o,
    output logic        CarryOut_o
);
    import muldiv_pkg::*;

    logic [32:0] sum;

    // Subtract is A + ~B + 1, so the carry out is the inverted borrow.
    always_comb begin
        sum = 33'd0;
        case (ALUCntl_i)
            ALU_AND: sum = {1'b0, A_i & B_i};
            ALU_OR:  sum = {1'b0, A_i | B_i};
            ALU_ADD: sum = {1'b0, A_i} + {1'b0, B_i} + {32'd0, CarryIn_i};
            ALU_SUB: sum = {1'b0, A_i} + {1'b0, ~B_i} + 33'd1;
            default: sum = 33'd0;
        endcase
    end

    assign ALUOut_o   = sum[31:0];
    assign CarryOut_o = sum[32];

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Iterative MIPS-style HI/LO multiply/divide unit. A start in IDLE latches
// op/A/B; the FSM walks PREP (magnitudes and signs), 32 ITER steps on the
// shared ALU, FIX (sign correction / divide-by-zero result) and DONE.
// HI/LO and done are registered on the edge that leaves DONE.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, op[1:0]     request and operation (MULT, MULTU, DIV, DIVU)
//   A, B [31:0]        operands
//   hi_we, lo_we       MTHI/MTLO strobes (honoured only when not busy)
//   wdata [31:0]       MTHI/MTLO data
//   HI, LO [31:0]      result registers
//   busy, done         operation in progress / one-cycle completion pulse
//   div_zero           last divide had B == 0, held until the next start
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    import muldiv_pkg::*;

    logic [2:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] aRaw_q, aRaw_d, bRaw_q, bRaw_d;
    logic [31:0] opnd_q, opnd_d, workHi_q, workHi_d, workLo_q, workLo_d;
    logic        resNeg_q, resNeg_d, remNeg_q, remNeg_d, bZero_q, bZero_d;
    logic [31:0] hiReg_q, hiReg_d, loReg_q, loReg_d;
    logic        busy_q, busy_d, done_q, done_d, divZero_q, divZero_d;

    logic [32:0] divShift;
    logic [3:0]  aluCntl;
    logic [31:0] aluA, aluOut;
    logic        aluCarry, divFits;
    logic [63:0] product;

    // Divide shifts the next dividend bit into the partial remainder before
    // the trial subtract; multiply adds the multiplicand into the high word.
    assign divShift = {workHi_q, workLo_q[31]};
    assign aluCntl  = isDivOp(op_q) ? ALU_SUB : ALU_ADD;
    assign aluA     = isDivOp(op_q) ? divShift[31:0] : workHi_q;

    muldiv_ctrl_alu uAlu (
        .ALUCntl_i (aluCntl),
        .A_i       (aluA),
        .B_i       (opnd_q),
        .CarryIn_i (1'b0),
        .ALUOut_o  (aluOut),
        .CarryOut_o(aluCarry)
    );

    // A set bit 32 in the shifted remainder already exceeds any 32-bit
    // divisor, and the low 32 bits of the subtract are then still exact.
    assign divFits = divShift[32] | aluCarry;

    // Next-state logic: MTHI/MTLO writes when idle, then the FSM datapath.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        aRaw_d    = aRaw_q;
        bRaw_d    = bRaw_q;
        opnd_d    = opnd_q;
        workHi_d  = workHi_q;
        workLo_d  = workLo_q;
        resNeg_d  = resNeg_q;
        remNeg_d  = remNeg_q;
        bZero_d   = bZero_q;
        hiReg_d   = hiReg_q;
        loReg_d   = loReg_q;
        busy_d    = busy_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;
        product   = {workHi_q, workLo_q};

        if (!busy_q) begin
            if (hi_we) hiReg_d = wdata;
            if (lo_we) loReg_d = wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    aRaw_d    = A;
                    bRaw_d    = B;
                    count_d   = 5'd0;
                    busy_d    = 1'b1;
                    divZero_d = 1'b0;
                    state_d   = ST_PREP;
                end
            end
            ST_PREP: begin
                bZero_d  = (bRaw_q == 32'd0);
                resNeg_d = isSignedOp(op_q) & (aRaw_q[31] ^ bRaw_q[31]);
                remNeg_d = isSignedOp(op_q) & aRaw_q[31];
                workHi_d = 32'd0;
                if (isDivOp(op_q)) begin
                    workLo_d = magnitude(aRaw_q, isSignedOp(op_q));
                    opnd_d   = magnitude(bRaw_q, isSignedOp(op_q));
                end else begin
                    opnd_d   = magnitude(aRaw_q, isSignedOp(op_q));
                    workLo_d = magnitude(bRaw_q, isSignedOp(op_q));
                end
                state_d = ST_ITER;
            end
            ST_ITER: begin
                if (isDivOp(op_q)) begin
                    workHi_d = divFits ? aluOut : divShift[31:0];
                    workLo_d = {workLo_q[30:0], divFits};
                end else if (workLo_q[0]) begin
                    {workHi_d, workLo_d} = {aluCarry, aluOut, workLo_q[31:1]};
                end else begin
                    {workHi_d, workLo_d} = {1'b0, workHi_q, workLo_q[31:1]};
                end
                count_d = count_q + 5'd1;
                if (count_q == ITER_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!isDivOp(op_q)) begin
                    if (resNeg_q) product = -product;
                    {workHi_d, workLo_d} = product;
                end else if (bZero_q) begin
                    workHi_d = aRaw_q;
                    workLo_d = 32'hFFFF_FFFF;
                end else begin
                    workLo_d = resNeg_q ? -workLo_q : workLo_q;
                    workHi_d = remNeg_q ? -workHi_q : workHi_q;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                hiReg_d   = workHi_q;
                loReg_d   = workLo_q;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                divZero_d = isDivOp(op_q) & bZero_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any operation and clears the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= 5'd0;
            op_q      <= 2'b00;
            aRaw_q    <= 32'd0;
            bRaw_q    <= 32'd0;
            opnd_q    <= 32'd0;
            workHi_q  <= 32'd0;
            workLo_q  <= 32'd0;
            resNeg_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            bZero_q   <= 1'b0;
            hiReg_q   <= 32'd0;
            loReg_q   <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            aRaw_q    <= aRaw_d;
            bRaw_q    <= bRaw_d;
            opnd_q    <= opnd_d;
            workHi_q  <= workHi_d;
            workLo_q  <= workLo_d;
            resNeg_q  <= resNeg_d;
            remNeg_q  <= remNeg_d;
            bZero_q   <= bZero_d;
            hiReg_q   <= hiReg_d;
            loReg_q   <= loReg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divZero_q <= divZero_d;
        end
    end

    assign HI       = hiReg_q;
    assign LO       = loReg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divZero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] A, B, wdata;
    logic [31:0] HI, LO;
    logic        busy, done, div_zero;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] modelHi, modelLo;
    logic        modelDz;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy),
        .done    (done),
        .div_zero(div_zero)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference results straight from integer arithmetic: 64-bit products,
    // truncating division with the remainder following the dividend.
    function automatic void refModel(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        dz = 1'b0;
        hi = 32'd0;
        lo = 32'd0;
        case (o)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    lo = 32'(q); hi = 32'(r);
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Runs one operation from the cycle before acceptance through the done
    // pulse. With interfere set, a second start arrives in ITER cycle 5 and
    // MTHI/MTLO strobes in ITER cycle 6; none of them may have any effect.
    task automatic applyStimulus(input string name, input logic [1:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit interfere);
        logic [31:0] eHi, eLo;
        logic        eDz;
        int          doneEdge, extraDone;
        refModel(o, a, b, eHi, eLo, eDz);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); A = $urandom; B = $urandom;
        checkOutput({name, " busy after accept"}, 64'(busy), 64'(1));
        checkOutput({name, " div_zero cleared"}, 64'(div_zero), 64'(0));
        doneEdge = 0;
        for (int k = 1; k <= 40 && doneEdge == 0; k++) begin
            if (interfere && k == 6) begin
                start = 1'b1; op = 2'($urandom); A = $urandom; B = $urandom;
            end
            if (interfere && k == 7) begin
                start = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end
            if (interfere && k == 8) begin
                hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk); #1;
            if (k == 20) begin
                checkOutput({name, " HI held"}, 64'(HI), 64'(modelHi));
                checkOutput({name, " LO held"}, 64'(LO), 64'(modelLo));
            end
            if (done) doneEdge = k;
        end
        checkOutput({name, " done edge"}, 64'(doneEdge), 64'(35));
        checkOutput({name, " busy at done"}, 64'(busy), 64'(0));
        checkOutput({name, " HI"}, 64'(HI), 64'(eHi));
        checkOutput({name, " LO"}, 64'(LO), 64'(eLo));
        checkOutput({name, " div_zero"}, 64'(div_zero), 64'(eDz));
        modelHi = eHi; modelLo = eLo; modelDz = eDz;
        @(posedge clk); #1;
        checkOutput({name, " done pulse width"}, 64'(done), 64'(0));
        checkOutput({name, " div_zero held"}, 64'(div_zero), 64'(modelDz));
        if (interfere) begin
            extraDone = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) extraDone++;
            end
            checkOutput({name, " no second done"}, 64'(extraDone), 64'(0));
            checkOutput({name, " HI after ignore"}, 64'(HI), 64'(modelHi));
        end
    endtask

    initial begin
        logic [31:0] w, ra, rb;
        logic [1:0]  ro;
        int          doneCount;

        rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; A = 32'd0; B = 32'd0; wdata = 32'd0;
        modelHi = 32'd0; modelLo = 32'd0; modelDz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset HI", 64'(HI), 64'(0));
        checkOutput("reset LO", 64'(LO), 64'(0));
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset div_zero", 64'(div_zero), 64'(0));
        rst = 1'b0;

        applyStimulus("mult 7*-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
        applyStimulus("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        applyStimulus("divu 100/0", 2'b11, 32'd100, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("div_zero held idle", 64'(div_zero), 64'(1));
        applyStimulus("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        applyStimulus("div -9/0", 2'b10, 32'hFFFF_FFF7, 32'd0, 1'b0);

        // MTHI / MTLO while idle.
        w = $urandom;
        hi_we = 1'b1; wdata = w;
        @(posedge clk); #1;
        hi_we = 1'b0;
        modelHi = w;
        checkOutput("mthi", 64'(HI), 64'(modelHi));
        checkOutput("mthi LO untouched", 64'(LO), 64'(modelLo));
        w = $urandom;
        lo_we = 1'b1; wdata = w;
        @(posedge clk); #1;
        lo_we = 1'b0;
        modelLo = w;
        checkOutput("mtlo", 64'(LO), 64'(modelLo));

        // MTHI coinciding with an accepted start: write lands, op still runs.
        w = $urandom;
        hi_we = 1'b1; wdata = w;
        modelHi = w;
        applyStimulus("mthi with start", 2'b01, 32'd123456, 32'd789, 1'b0);

        applyStimulus("ignored start/mthi", 2'b00, $urandom, $urandom, 1'b1);

        // Reset in ITER cycle 10 aborts the operation immediately.
        start = 1'b1; op = 2'b10; A = 32'd1000; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort busy", 64'(busy), 64'(0));
        checkOutput("abort HI", 64'(HI), 64'(0));
        checkOutput("abort LO", 64'(LO), 64'(0));
        checkOutput("abort done", 64'(done), 64'(0));
        modelHi = 32'd0; modelLo = 32'd0; modelDz = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        doneCount = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) doneCount++;
        end
        checkOutput("no done after abort", 64'(doneCount), 64'(0));
        applyStimulus("after abort", 2'b10, 32'hFFFF_FC18, 32'd7, 1'b0);

        // Randomized operations with a bias toward corner operands.
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            applyStimulus("random", ro, ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
